// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state and reset-cause encodings for the reset sequencer.
package reset_seq_pkg;
  typedef enum logic [2:0] {ASSERT, WAIT_LOCK, STRETCH, STAGGER, RUN} state_t;
  localparam logic [1:0] CAUSE_MASTER = 2'b00;
  localparam logic [1:0] CAUSE_SOFT   = 2'b01;
  localparam logic [1:0] CAUSE_LOCK   = 2'b10;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep synchroniser chain for one asynchronous bit, cleared by async reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-gated, stretched, in-order release of N active-low reset channels.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int LOCKS       = 2,
  parameter int DELAY_W     = 6,
  parameter int GAP         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SOFT_MIN    = 4
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iSOFT_RST,
  input  logic [LOCKS-1:0]    iLOCKED,
  output logic [CHANNELS-1:0] oRESETn,
  output logic                oREADY,
  output logic [1:0]          oCAUSE
);
  localparam int CW = (DELAY_W + 1 > $clog2(GAP) + 1) ? DELAY_W + 1 : $clog2(GAP) + 1;
  localparam int SW = $clog2(SOFT_MIN + 1);
  localparam logic [CW-1:0] STRETCH_END = CW'((1 << DELAY_W) - 1);
  localparam logic [CW-1:0] GAP_END     = CW'(GAP - 1);
  localparam logic [SW-1:0] SOFT_END    = SW'(SOFT_MIN - 1);

  logic [LOCKS:0]    w_raw, w_sync;
  logic              w_lock_ok, w_soft, w_soft_ok, w_lock_lost;
  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [CHANNELS-1:0] r_rel, w_rel, w_shift;
  logic              r_ready, w_ready;
  logic [1:0]        r_cause, w_cause;
  logic [SW-1:0]     r_soft_cnt, w_soft_cnt;

  assign w_raw = {iSOFT_RST, iLOCKED};
  for (genvar i = 0; i <= LOCKS; i++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk(iCLK),
      .i_rst(iRESET),
      .i_d  (w_raw[i]),
      .o_q  (w_sync[i])
    );
  end

  assign w_lock_ok   = &w_sync[LOCKS-1:0];
  assign w_soft      = w_sync[LOCKS];
  // soft_ok on the SOFT_MIN-th consecutive synchronised-high cycle
  assign w_soft_ok   = w_soft && (r_soft_cnt == SOFT_END);
  assign w_lock_lost = !w_lock_ok && (r_state inside {STRETCH, STAGGER, RUN});
  assign w_shift     = CHANNELS'({r_rel, 1'b1});

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_rel      = r_rel;
    w_ready    = r_ready;
    w_cause    = r_cause;
    w_soft_cnt = !w_soft ? '0 : w_soft_ok ? r_soft_cnt : r_soft_cnt + 1'b1;
    case (r_state)
      ASSERT:
        if (!w_soft_ok) begin
          w_state = WAIT_LOCK;
          w_cnt   = '0;
        end
      WAIT_LOCK:
        if (w_lock_ok) begin
          w_state = STRETCH;
          w_cnt   = '0;
        end
      STRETCH:
        if (r_cnt == STRETCH_END) begin
          w_rel   = CHANNELS'(1);
          w_state = (CHANNELS == 1) ? RUN : STAGGER;
          w_ready = (CHANNELS == 1);
          w_cnt   = '0;
        end else w_cnt = r_cnt + 1'b1;
      STAGGER:
        if (r_cnt == GAP_END) begin
          w_rel   = w_shift;
          w_state = &w_shift ? RUN : STAGGER;
          w_ready = &w_shift;
          w_cnt   = '0;
        end else w_cnt = r_cnt + 1'b1;
      default: ;
    endcase
    if (r_state != ASSERT && (w_soft_ok || w_lock_lost)) begin
      w_state = ASSERT;
      w_cnt   = '0;
      w_rel   = '0;
      w_ready = 1'b0;
      w_cause = w_lock_lost ? CAUSE_LOCK : CAUSE_SOFT;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET)
    if (iRESET) begin
      r_state    <= ASSERT;
      r_cnt      <= '0;
      r_rel      <= '0;
      r_ready    <= 1'b0;
      r_cause    <= CAUSE_MASTER;
      r_soft_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_rel      <= w_rel;
      r_ready    <= w_ready;
      r_cause    <= w_cause;
      r_soft_cnt <= w_soft_cnt;
    end

  assign oRESETn = r_rel;
  assign oREADY  = r_ready;
  assign oCAUSE  = r_cause;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and random checks of reset_sequencer against a timestamp-based model.
module tb_reset_sequencer;
  localparam int C = 3, D = 6, G = 8, S = 2, SM = 4;

  logic       iCLK, iRESET, iSOFT_RST;
  logic [1:0] iLOCKED;
  logic [2:0] oRESETn;
  logic       oREADY;
  logic [1:0] oCAUSE;
  logic       o2_rstn, o2_rdy;
  logic [1:0] o2_cause;

  reset_sequencer dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSOFT_RST(iSOFT_RST), .iLOCKED(iLOCKED),
    .oRESETn(oRESETn), .oREADY(oREADY), .oCAUSE(oCAUSE)
  );
  reset_sequencer #(.CHANNELS(1), .LOCKS(1), .DELAY_W(2)) dut2 (
    .iCLK(iCLK), .iRESET(iRESET), .iSOFT_RST(1'b0), .iLOCKED(1'b1),
    .oRESETn(o2_rstn), .oREADY(o2_rdy), .oCAUSE(o2_cause)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_cmp = 0, n_bad = 0;
  bit lq[$], sq[$];
  int mode, t;
  logic [1:0] m_cause;
  logic [2:0] exp_rst;
  logic       exp_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 all asserted, 1 waiting for lock, 2 sequencing (t = cycles since lock accepted)
  task automatic model_reset();
    lq.delete();
    sq.delete();
    for (int i = 0; i < S + SM; i++) begin
      lq.push_back(1'b0);
      sq.push_back(1'b0);
    end
    mode = 0; t = 0; m_cause = 2'b00;
  endtask

  task automatic model_step();
    bit lock_ok, soft_ok;
    int nrel;
    lq.push_front(&iLOCKED);
    sq.push_front(iSOFT_RST);
    void'(lq.pop_back());
    void'(sq.pop_back());
    lock_ok = lq[S];
    soft_ok = 1'b1;
    for (int i = S; i < S + SM; i++) soft_ok &= sq[i];
    if (mode == 2 && (!lock_ok || soft_ok)) begin
      mode = 0;
      m_cause = !lock_ok ? 2'b10 : 2'b01;
    end else if (mode == 1 && soft_ok) begin
      mode = 0;
      m_cause = 2'b01;
    end else if (mode == 2) t++;
    else if (mode == 1 && lock_ok) begin
      mode = 2;
      t = 0;
    end else if (mode == 0 && !soft_ok) mode = 1;
    nrel = (mode == 2 && t >= (1 << D)) ? 1 + (t - (1 << D)) / G : 0;
    if (nrel > C) nrel = C;
    exp_rst = 3'((32'd1 << nrel) - 1);
    exp_rdy = (nrel == C);
  endtask

  task automatic tick();
    @(posedge iCLK);
    if (iRESET) begin
      model_reset();
      exp_rst = 3'b000;
      exp_rdy = 1'b0;
    end else model_step();
    #1;
    check("model_rstn", 32'(oRESETn), 32'(exp_rst));
    check("model_ready", 32'(oREADY), 32'(exp_rdy));
    check("model_cause", 32'(oCAUSE), 32'(m_cause));
  endtask

  task automatic wait_rel(input logic [2:0] pat, input int lim, output int n);
    n = 0;
    while (oRESETn !== pat && n < lim) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, soft_len;
    iRESET = 1'b1; iSOFT_RST = 1'b0; iLOCKED = 2'b11;
    model_reset();
    repeat (3) tick();
    check("reset_rstn", 32'(oRESETn), 32'd0);
    check("reset_cause", 32'(oCAUSE), 32'd0);
    iRESET = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k inside {66, 67, 74, 75, 82, 83})
        check("t1_release", 32'(oRESETn), k < 67 ? 32'd0 : k < 75 ? 32'd1 : k < 83 ? 32'd3 : 32'd7);
      if (k inside {82, 83}) check("t1_ready", 32'(oREADY), 32'(k == 83));
      if (k inside {6, 7}) begin
        check("ch1_rstn", 32'(o2_rstn), 32'(k == 7));
        check("ch1_ready", 32'(o2_rdy), 32'(k == 7));
        check("ch1_cause", 32'(o2_cause), 32'd0);
      end
    end
    check("t1_cause", 32'(oCAUSE), 32'd0);

    iRESET = 1'b1;
    tick();
    iLOCKED = 2'b01;
    iRESET = 1'b0;
    repeat (200) tick();
    check("t2_hold", 32'(oRESETn), 32'd0);
    iLOCKED = 2'b11;
    wait_rel(3'b001, 100, n);
    check("t2_latency", 32'(n), 32'd67);
    wait_rel(3'b111, 100, n);
    repeat (5) tick();

    iSOFT_RST = 1'b1;
    repeat (3) tick();
    iSOFT_RST = 1'b0;
    repeat (10) tick();
    check("t3_short_rstn", 32'(oRESETn), 32'd7);
    check("t3_short_ready", 32'(oREADY), 32'd1);
    iSOFT_RST = 1'b1;
    wait_rel(3'b000, 20, n);
    check("t3_soft_latency", 32'(n), 32'd6);
    check("t3_cause", 32'(oCAUSE), 32'd1);
    repeat (4) tick();
    check("t3_held", 32'(oRESETn), 32'd0);
    iSOFT_RST = 1'b0;
    wait_rel(3'b001, 100, n);
    check("t3_reseq", 32'(n), 32'd68);

    iLOCKED = 2'b10;
    iSOFT_RST = 1'b1;
    wait_rel(3'b000, 20, n);
    check("t4_lock_latency", 32'(n), 32'd3);
    check("t4_cause", 32'(oCAUSE), 32'd2);
    iLOCKED = 2'b11;
    iSOFT_RST = 1'b0;
    wait_rel(3'b001, 100, n);
    check("t4b_reseq", 32'(oRESETn), 32'd1);
    iSOFT_RST = 1'b1;
    repeat (3) tick();
    iLOCKED = 2'b10;
    wait_rel(3'b000, 20, n);
    check("t4b_same_edge", 32'(n), 32'd3);
    check("t4b_cause", 32'(oCAUSE), 32'd2);
    iLOCKED = 2'b11;
    iSOFT_RST = 1'b0;

    repeat (10) tick();
    #3 iRESET = 1'b1;
    #1;
    check("t5_async_rstn", 32'(oRESETn), 32'd0);
    check("t5_async_ready", 32'(oREADY), 32'd0);
    check("t5_async_cause", 32'(oCAUSE), 32'd0);
    tick();
    iRESET = 1'b0;

    soft_len = 0;
    repeat (4000) begin
      tick();
      if (soft_len > 0) soft_len--;
      else if ($urandom_range(0, 119) == 0) soft_len = $urandom_range(1, 10);
      iSOFT_RST = (soft_len > 0);
      for (int b = 0; b < 2; b++) iLOCKED[b] = ($urandom_range(0, 399) != 0);
    end

    iLOCKED = 2'b11;
    iSOFT_RST = 1'b0;
    wait_rel(3'b111, 300, n);
    check("final_ready", 32'(oREADY), 32'd1);
    #3 iRESET = 1'b1;
    #1;
    check("final_async_rstn", 32'(oRESETn), 32'd0);
    check("final_async_ready", 32'(oREADY), 32'd0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
